// File: rtl/fetch_control_unit_if.sv
// Fetch/decode bundle between fetch_control_unit and the ROM/datapath side.
// master = the fetch unit (drives PC and controls), slave = ROM/datapath.
interface fetch_control_unit_if #(
   parameter int D = 12,
   parameter int A = 4
);
   logic [8:0]   mach_code;
   logic         one;
   logic [D-1:0] prog_ctr;
   logic [1:0]   InstType;
   logic         BranchInst;
   logic         MemRead;
   logic         MemWrite;
   logic         ALUSrc;
   logic         RegWrite;
   logic         MemtoReg;
   logic         isaddi;
   logic         ismovr;
   logic [A-1:0] ALUOp;
   logic         done;

   modport master (
      input  mach_code, one,
      output prog_ctr, InstType, BranchInst, MemRead, MemWrite, ALUSrc,
             RegWrite, MemtoReg, isaddi, ismovr, ALUOp, done
   );

   modport slave (
      output mach_code, one,
      input  prog_ctr, InstType, BranchInst, MemRead, MemWrite, ALUSrc,
             RegWrite, MemtoReg, isaddi, ismovr, ALUOp, done
   );
endinterface

// File: rtl/fetch_control_unit.sv
// Program counter, branch-target LUT, lagging "one" flag and opcode decoder
// for the 9-bit single-cycle core.
module fetch_control_unit #(
   parameter int D         = 12,
   parameter int A         = 4,
   parameter int DONE_ADDR = 31
) (
   input  logic                  clk,
   input  logic                  reset,
   fetch_control_unit_if.master  bus
);

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_SHL  = 5'b00101;
   localparam logic [4:0] OP_SHR  = 5'b00110;
   localparam logic [4:0] OP_CMP  = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SW   = 5'b01001;
   localparam logic [4:0] OP_ADDI = 5'b01010;
   localparam logic [4:0] OP_MOVR = 5'b01011;
   localparam logic [4:0] OP_BEQ  = 5'b01100;
   localparam logic [4:0] OP_JMP  = 5'b01101;
   localparam logic [4:0] OP_BRR  = 5'b01110;

   logic [4:0]   op;
   logic [D-1:0] pc_p0;
   logic         one_q_p0;
   logic [D-1:0] target;
   logic [D-1:0] pc_nxt;
   logic         absj;
   logic         relj;

   logic [1:0]   inst_type;
   logic         branch_inst;
   logic         mem_read;
   logic         mem_write;
   logic         alu_src;
   logic         reg_write;
   logic         mem_to_reg;
   logic         is_addi;
   logic         is_movr;
   logic [A-1:0] alu_op;
   logic         is_beq;
   logic         is_jmp;
   logic         is_brr;

   // Branch-target table: 4-bit index selects an address nibble, scaled by 16.
   function automatic logic [3:0] pc_lut(input logic [3:0] idx);
      logic [3:0] addr;
      case (idx)
         4'd0:    addr = 4'd0;
         4'd1:    addr = 4'd1;
         4'd2:    addr = 4'd2;
         4'd3:    addr = 4'd3;
         4'd4:    addr = 4'd4;
         4'd5:    addr = 4'd5;
         4'd6:    addr = 4'd6;
         4'd7:    addr = 4'd7;
         4'd8:    addr = 4'd8;
         4'd9:    addr = 4'd9;
         4'd10:   addr = 4'd10;
         4'd11:   addr = 4'd11;
         4'd12:   addr = 4'd12;
         4'd13:   addr = 4'd13;
         4'd14:   addr = 4'd14;
         default: addr = 4'd15;
      endcase
      return addr;
   endfunction

   // PC arithmetic wraps modulo 2^D.
   function automatic logic [D-1:0] pc_add(input logic [D-1:0] a,
                                           input logic [D-1:0] b);
      return a + b;
   endfunction

   assign op     = bus.mach_code[8:4];
   assign target = D'({pc_lut(bus.mach_code[3:0]), 4'b0000});

   always_comb begin
      inst_type   = 2'b00;
      branch_inst = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      alu_src     = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      is_addi     = 1'b0;
      is_movr     = 1'b0;
      alu_op      = '0;
      is_beq      = 1'b0;
      is_jmp      = 1'b0;
      is_brr      = 1'b0;
      if (op[4:3] == 2'b11) begin
         inst_type = 2'b10;
         reg_write = 1'b1;
      end else begin
         case (op)
            OP_ADD: begin reg_write = 1'b1; alu_op = A'(4'b0000); end
            OP_SUB: begin reg_write = 1'b1; alu_op = A'(4'b0001); end
            OP_AND: begin reg_write = 1'b1; alu_op = A'(4'b0010); end
            OP_OR:  begin reg_write = 1'b1; alu_op = A'(4'b0011); end
            OP_XOR: begin reg_write = 1'b1; alu_op = A'(4'b0100); end
            OP_SHL: begin reg_write = 1'b1; alu_op = A'(4'b0101); end
            OP_SHR: begin reg_write = 1'b1; alu_op = A'(4'b0110); end
            OP_CMP: alu_op = A'(4'b0111);
            OP_LW: begin
               inst_type  = 2'b01;
               mem_read   = 1'b1;
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
               alu_op     = A'(4'b1000);
            end
            OP_SW: begin
               mem_write = 1'b1;
               alu_op    = A'(4'b1000);
            end
            OP_ADDI: begin
               alu_src   = 1'b1;
               is_addi   = 1'b1;
               reg_write = 1'b1;
            end
            OP_MOVR: begin
               is_movr   = 1'b1;
               reg_write = 1'b1;
               alu_op    = A'(4'b1001);
            end
            OP_BEQ: begin
               inst_type   = 2'b11;
               branch_inst = 1'b1;
               is_beq      = 1'b1;
            end
            OP_JMP: begin
               inst_type = 2'b11;
               is_jmp    = 1'b1;
            end
            OP_BRR: begin
               inst_type = 2'b11;
               is_brr    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Branches consume the flag captured on the previous edge, so a CMP
   // steers the branch that follows it.
   assign absj = (is_beq & one_q_p0) | is_jmp;
   assign relj = is_brr & one_q_p0;

   always_comb begin
      pc_nxt = pc_add(pc_p0, D'(1));
      if (absj)      pc_nxt = target;
      else if (relj) pc_nxt = pc_add(pc_p0, target);
   end

   // Stage p0: PC and flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_p0    <= '0;
         one_q_p0 <= 1'b0;
      end else begin
         pc_p0    <= pc_nxt;
         one_q_p0 <= bus.one;
      end
   end

   assign bus.prog_ctr   = pc_p0;
   assign bus.done       = (pc_p0 == D'(DONE_ADDR));
   assign bus.InstType   = inst_type;
   assign bus.BranchInst = branch_inst;
   assign bus.MemRead    = mem_read;
   assign bus.MemWrite   = mem_write;
   assign bus.ALUSrc     = alu_src;
   assign bus.RegWrite   = reg_write;
   assign bus.MemtoReg   = mem_to_reg;
   assign bus.isaddi     = is_addi;
   assign bus.ismovr     = is_movr;
   assign bus.ALUOp      = alu_op;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed bench for fetch_control_unit: decode table, branching, wrap and done.
module tb_fetch_control_unit;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   fetch_control_unit_if #(.D(12), .A(4)) bus ();

   fetch_control_unit #(.D(12), .A(4), .DONE_ADDR(31)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   localparam logic [8:0] NOP = 9'b01111_0000;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      reset = 1'b1;
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [15:0] ctl_vec();
      return {bus.InstType, bus.BranchInst, bus.MemRead, bus.MemWrite, bus.ALUSrc,
              bus.RegWrite, bus.MemtoReg, bus.isaddi, bus.ismovr, bus.ALUOp};
   endfunction

   // {InstType, Br, MemRd, MemWr, ALUSrc, RegWr, MemtoReg, addi, movr, ALUOp}
   logic [4:0]  ops  [18];
   logic [15:0] exps [18];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      ops  = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
               5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
               5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000, 5'b10111};
      exps = '{16'b00_0000_1000_0000, 16'b00_0000_1000_0001, 16'b00_0000_1000_0010,
               16'b00_0000_1000_0011, 16'b00_0000_1000_0100, 16'b00_0000_1000_0101,
               16'b00_0000_1000_0110, 16'b00_0000_0000_0111, 16'b01_0100_1100_1000,
               16'b00_0010_0000_1000, 16'b00_0001_1010_0000, 16'b00_0000_1001_1001,
               16'b11_1000_0000_0000, 16'b11_0000_0000_0000, 16'b11_0000_0000_0000,
               16'b00_0000_0000_0000, 16'b00_0000_0000_0000, 16'b00_0000_0000_0000};

      reset = 1'b1;
      bus.mach_code = NOP;
      bus.one = 1'b0;
      #2;
      chk("reset_pc", 32'(bus.prog_ctr), 0);
      chk("reset_done", 32'(bus.done), 0);

      for (int i = 0; i < 18; i++) begin
         bus.mach_code = {ops[i], 4'b0101};
         #1;
         chk($sformatf("decode_%05b", ops[i]), 32'(ctl_vec()), 32'(exps[i]));
      end
      bus.mach_code = 9'b1_1010_0110;
      #1;
      chk("decode_li", 32'(ctl_vec()), 32'(16'b10_0000_1000_0000));

      // one=1 during reset must not leak into the first branch
      bus.one = 1'b1;
      bus.mach_code = {5'b01100, 4'd3};
      tick();
      reset = 1'b0;
      tick();
      chk("post_reset_beq", 32'(bus.prog_ctr), 1);
      bus.one = 1'b0;
      bus.mach_code = NOP;
      repeat (6) tick();
      chk("count_to_7", 32'(bus.prog_ctr), 7);

      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_pc", 32'(bus.prog_ctr), 0);
      tick();
      reset = 1'b0;
      chk("held_reset_pc", 32'(bus.prog_ctr), 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("count_%0d", i), 32'(bus.prog_ctr), 32'(i));
      end

      tick();
      bus.mach_code = {5'b00111, 4'd0};
      bus.one = 1'b1;
      tick();
      bus.mach_code = {5'b01100, 4'd3};
      bus.one = 1'b0;
      tick();
      chk("beq_taken", 32'(bus.prog_ctr), 48);

      rst_pulse();
      bus.mach_code = NOP;
      repeat (4) tick();
      bus.mach_code = {5'b00111, 4'd0};
      bus.one = 1'b0;
      tick();
      bus.mach_code = {5'b01100, 4'd3};
      tick();
      chk("beq_not_taken", 32'(bus.prog_ctr), 6);

      bus.mach_code = {5'b01101, 4'd2};
      tick();
      chk("jmp_oneq0", 32'(bus.prog_ctr), 32);
      bus.mach_code = NOP;
      bus.one = 1'b1;
      tick();
      bus.mach_code = {5'b01101, 4'd2};
      bus.one = 1'b0;
      tick();
      chk("jmp_oneq1", 32'(bus.prog_ctr), 32);

      bus.mach_code = NOP;
      repeat (7) tick();
      bus.one = 1'b1;
      tick();
      chk("pc_40", 32'(bus.prog_ctr), 40);
      bus.one = 1'b0;
      bus.mach_code = {5'b01110, 4'd1};
      tick();
      chk("brr_taken", 32'(bus.prog_ctr), 56);
      tick();
      chk("brr_not_taken", 32'(bus.prog_ctr), 57);

      rst_pulse();
      bus.mach_code = NOP;
      for (int i = 1; i <= 4090; i++) begin
         if (i == 4090) bus.one = 1'b1;
         tick();
      end
      chk("pc_4090", 32'(bus.prog_ctr), 4090);
      bus.one = 1'b0;
      bus.mach_code = {5'b01110, 4'd15};
      tick();
      chk("brr_wrap", 32'(bus.prog_ctr), 234);

      rst_pulse();
      bus.mach_code = NOP;
      repeat (4095) tick();
      chk("pc_4095", 32'(bus.prog_ctr), 4095);
      tick();
      chk("nop_wrap", 32'(bus.prog_ctr), 0);

      rst_pulse();
      for (int i = 0; i <= 40; i++) begin
         chk($sformatf("done_at_%0d", i), 32'(bus.done), (i == 31) ? 1 : 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
